// File: rtl/data_memory_ws.sv
// data_memory_ws: MEM-stage data memory with programmable wait states and a ready handshake.
// Every access takes WAIT_CYCLES+2 cycles (IDLE -> BUSY x (WAIT_CYCLES+1) -> DONE).
// Out-of-range or misaligned accesses are flagged and never alias onto a valid word.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset (clears FSM and every memory word)
//   mem_w_en  write request, held until ready
//   mem_r_en  read request, held until ready (write wins if both are set)
//   alu_res   byte address
//   val_rm    write data
//   out       read data in the DONE cycle of a read, else 0
//   ready     access complete / no request pending
//   addr_err  high in the DONE cycle of a faulting access
module data_memory_ws #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_w_en,
  input  logic              mem_r_en,
  input  logic [31:0]       alu_res,
  input  logic [DATA_W-1:0] val_rm,
  output logic [DATA_W-1:0] out,
  output logic              ready,
  output logic              addr_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_wr;
  logic [IDX_W-1:0]    r_idx;
  logic                r_err;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_req;
  logic [31:0]         w_offset;
  logic                w_err;
  logic [IDX_W-1:0]    w_idx;

  // Address decode: offset wraps, so addresses below the base land far out of range.
  assign w_req    = mem_r_en | mem_w_en;
  assign w_offset = alu_res - 32'(BASE_ADDR);
  assign w_err    = (w_offset >= 32'(DEPTH * 4)) || (alu_res[1:0] != 2'b00);
  assign w_idx    = w_offset[IDX_W+1:2];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    out         = '0;
    addr_err    = 1'b0;
    case (r_state)
      IDLE: begin
        ready = ~w_req;
        if (w_req) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (r_cnt == '0) w_state_nxt = DONE;
      end
      DONE: begin
        ready       = 1'b1;
        addr_err    = r_err;
        out         = r_wr ? '0 : r_rdata;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request latch, wait counter and the memory array itself
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_mem   <= '{default: '0};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_wr    <= mem_w_en;
            r_idx   <= w_idx;
            r_err   <= w_err;
            r_wdata <= val_rm;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (r_wr) begin
            if (!r_err) r_mem[r_idx] <= r_wdata;
          end else begin
            r_rdata <= r_err ? '0 : r_mem[r_idx];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench for data_memory_ws: one instance with 3 wait states, one with none.
module tb_data_memory_ws;

  logic        clk;
  logic        rst;
  logic        w_en [2];
  logic        r_en [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [31:0] q    [2];
  logic        rdy  [2];
  logic        aerr [2];

  int n_cmp;
  int n_err;

  data_memory_ws #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .mem_w_en(w_en[0]), .mem_r_en(r_en[0]),
    .alu_res(addr[0]), .val_rm(wdat[0]), .out(q[0]), .ready(rdy[0]), .addr_err(aerr[0])
  );

  data_memory_ws #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_w_en(w_en[1]), .mem_r_en(r_en[1]),
    .alu_res(addr[1]), .val_rm(wdat[1]), .out(q[1]), .ready(rdy[1]), .addr_err(aerr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request in the current (IDLE) cycle; sampling happens #1 after the negedge.
  task automatic start(input int s, input logic wr, input logic rd,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    w_en[s] = wr;
    r_en[s] = rd;
    addr[s] = a;
    wdat[s] = d;
    #1;
  endtask

  // Count cycles until ready, capture DONE-cycle outputs, then drop the request.
  task automatic wait_done(input int s, output int lat, output logic [31:0] o, output logic e);
    lat = 0;
    while (rdy[s] !== 1'b1 && lat < 50) begin
      @(negedge clk);
      #1;
      lat++;
    end
    o = q[s];
    e = aerr[s];
    w_en[s] = 1'b0;
    r_en[s] = 1'b0;
  endtask

  task automatic xfer(input int s, input logic wr, input logic rd, input logic [31:0] a,
                      input logic [31:0] d, input int exp_lat, input logic [31:0] exp_o,
                      input logic exp_e, input string tag);
    int          lat;
    logic [31:0] o;
    logic        e;
    start(s, wr, rd, a, d);
    wait_done(s, lat, o, e);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_out"}, o, exp_o);
    check({tag, "_err"}, 32'(e), 32'(exp_e));
  endtask

  initial begin
    int          lat;
    logic [31:0] o;
    logic        e;
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 2; i++) begin
      w_en[i] = 1'b0;
      r_en[i] = 1'b0;
      addr[i] = '0;
      wdat[i] = '0;
    end
    rst = 1'b0;

    // Reset state: ready follows ~req, data outputs idle
    @(negedge clk);
    #1;
    check("rst_ready", 32'(rdy[0]), 32'd1);
    check("rst_out", q[0], 32'd0);
    check("rst_err", 32'(aerr[0]), 32'd0);
    w_en[0] = 1'b1;
    #1;
    check("rst_ready_req", 32'(rdy[0]), 32'd0);
    w_en[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // T1: 3 wait states -> ready in cycle 5
    xfer(0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 5, 32'd0, 1'b0, "t1_wr");
    xfer(0, 1'b0, 1'b1, 32'd1028, 32'd0, 5, 32'hDEADBEEF, 1'b0, "t1_rd");

    // T2: zero wait states, back-to-back -> ready every 3rd cycle
    for (int i = 0; i < 3; i++)
      xfer(1, 1'b1, 1'b0, 32'(1024 + 4 * i), 32'(i + 1), 2, 32'd0, 1'b0, "t2_wr");
    for (int i = 0; i < 3; i++)
      xfer(1, 1'b0, 1'b1, 32'(1024 + 4 * i), 32'd0, 2, 32'(i + 1), 1'b0, "t2_rd");

    // T3: out-of-range and misaligned writes are flagged and suppressed
    xfer(0, 1'b1, 1'b0, 32'd1280, 32'h55, 5, 32'd0, 1'b1, "t3_wr_oor");
    xfer(0, 1'b1, 1'b0, 32'd1026, 32'h55, 5, 32'd0, 1'b1, "t3_wr_mis");
    for (int a = 1024; a <= 1276; a += 4)
      xfer(0, 1'b0, 1'b1, 32'(a), 32'd0, 5, (a == 1028) ? 32'hDEADBEEF : 32'd0, 1'b0, "t3_rd");
    xfer(0, 1'b0, 1'b1, 32'd1280, 32'd0, 5, 32'd0, 1'b1, "t3_rd_oor");
    xfer(0, 1'b0, 1'b1, 32'd1020, 32'd0, 5, 32'd0, 1'b1, "t3_rd_below");

    // T4: both enables -> write, out stays 0
    xfer(0, 1'b1, 1'b1, 32'd1040, 32'hA5, 5, 32'd0, 1'b0, "t4_both");
    xfer(0, 1'b0, 1'b1, 32'd1040, 32'd0, 5, 32'hA5, 1'b0, "t4_rd");

    // T6: inputs changed while BUSY are ignored
    start(0, 1'b1, 1'b0, 32'd1056, 32'h77);
    @(negedge clk);
    @(negedge clk);
    addr[0] = 32'd1060;
    wdat[0] = 32'hFFFF;
    #1;
    wait_done(0, lat, o, e);
    check("t6_wr_out", o, 32'd0);
    check("t6_wr_err", 32'(e), 32'd0);
    xfer(0, 1'b0, 1'b1, 32'd1056, 32'd0, 5, 32'h77, 1'b0, "t6_rd_old");
    xfer(0, 1'b0, 1'b1, 32'd1060, 32'd0, 5, 32'd0, 1'b0, "t6_rd_new");

    // T5: reset mid-write aborts the access and clears memory
    start(0, 1'b1, 1'b0, 32'd1024, 32'h1234);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_ready_req", 32'(rdy[0]), 32'd0);
    check("t5_out", q[0], 32'd0);
    check("t5_err", 32'(aerr[0]), 32'd0);
    w_en[0] = 1'b0;
    #1;
    check("t5_ready_idle", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    xfer(0, 1'b0, 1'b1, 32'd1024, 32'd0, 5, 32'd0, 1'b0, "t5_rd_aborted");
    xfer(0, 1'b0, 1'b1, 32'd1028, 32'd0, 5, 32'd0, 1'b0, "t5_rd_cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
